// File: rtl/cpu_bus_master.sv
// cpu_bus_master
//
// Arbitrates between NREQ internal requesters and runs one complete
// configuration-bus cycle at a time. The bus speaks either Intel protocol
// (BusMode=1: separate active-low read/write strobes, active-high Rdy) or
// Motorola protocol (BusMode=0: active-low data strobe, R/W level,
// active-low Dtack). The mode is sampled once per transaction, at grant.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cfg_bus_mode      protocol select, sampled at grant
//   req_valid/ready   per-requester request handshake (ready is a 1-cycle one-hot pulse)
//   req_write         per-requester direction, 1=write
//   req_addr          packed addresses, requester i at [i*AW +: AW]
//   req_wdata         packed write data, requester i at [i*DW +: DW]
//   resp_valid        1-cycle completion pulse with resp_id/resp_rdata/resp_err
//   BusMode..Wr_RW    bus outputs to the peripheral (all registered)
//   DataOut           read data from the peripheral
//   Rdy_Dtack         acknowledge from the peripheral (polarity depends on mode)
//   busy              high whenever a transaction is in progress

module cpu_bus_master #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = 24,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_bus_mode,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_wdata,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [DW-1:0]            resp_rdata,
  output logic                     resp_err,
  output logic                     BusMode,
  output logic [AW-1:0]            Addr,
  output logic                     Sel,
  output logic [DW-1:0]            DataIn,
  output logic                     Rd_DS,
  output logic                     Wr_RW,
  input  logic [DW-1:0]            DataOut,
  input  logic                     Rdy_Dtack,
  output logic                     busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StRelease,
    StResp
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;     // last granted requester
  logic [IDW-1:0]   id_q;
  logic             wr_q;
  logic [CW-1:0]    cnt_q;     // strobe / release wait counter
  logic [DW-1:0]    rdata_q;
  logic             err_q;

  logic             ack;
  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  int unsigned      idx;

  // Normalise the acknowledge to active-high using the mode latched at grant.
  assign ack  = BusMode ? Rdy_Dtack : ~Rdy_Dtack;
  assign busy = (state_q != StIdle);

  // Round-robin search: start just after the last grant and wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[IDW'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

  // Accept is combinational so valid&ready meet on the IDLE cycle itself.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == StIdle && grant_found) begin
      req_ready = NREQ'(1) << grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= IDW'(NREQ - 1);
      id_q       <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      BusMode    <= 1'b1;
      Addr       <= '0;
      Sel        <= 1'b1;
      DataIn     <= '0;
      Rd_DS      <= 1'b1;
      Wr_RW      <= 1'b1;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            ptr_q   <= grant_id;
            id_q    <= grant_id;
            wr_q    <= req_write[grant_id];
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            BusMode <= cfg_bus_mode;
            Addr    <= req_addr[grant_id*AW +: AW];
            if (req_write[grant_id]) begin
              DataIn <= req_wdata[grant_id*DW +: DW];
            end
            Sel     <= 1'b0;
            // Motorola R/W level is set up a cycle ahead of the data strobe.
            Wr_RW   <= cfg_bus_mode ? 1'b1 : ~req_write[grant_id];
            state_q <= StSetup;
          end
        end

        StSetup: begin
          if (BusMode) begin
            Rd_DS <= wr_q;
            Wr_RW <= ~wr_q;
          end else begin
            Rd_DS <= 1'b0;
          end
          cnt_q   <= '0;
          state_q <= StStrobe;
        end

        StStrobe: begin
          if (ack) begin
            if (!wr_q) begin
              rdata_q <= DataOut;
            end
            Sel     <= 1'b1;
            Rd_DS   <= 1'b1;
            Wr_RW   <= 1'b1;
            cnt_q   <= '0;
            state_q <= StRelease;
          end else if (cnt_q == CntLast) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            Sel     <= 1'b1;
            Rd_DS   <= 1'b1;
            Wr_RW   <= 1'b1;
            cnt_q   <= '0;
            state_q <= StRelease;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StRelease: begin
          if (!ack || cnt_q == CntLast) begin
            // Ack still high on the last allowed cycle means a stuck peripheral.
            resp_valid <= 1'b1;
            resp_id    <= id_q;
            resp_err   <= err_q | ack;
            resp_rdata <= ack ? '0 : rdata_q;
            state_q    <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StResp: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
module tb_cpu_bus_master;

  localparam int NREQ    = 2;
  localparam int AW      = 24;
  localparam int DW      = 16;
  localparam int TIMEOUT = 16;
  localparam int IDW     = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_bus_mode;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_write;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic [DW-1:0]       resp_rdata;
  logic                resp_err;
  logic                BusMode;
  logic [AW-1:0]       Addr;
  logic                Sel;
  logic [DW-1:0]       DataIn;
  logic                Rd_DS;
  logic                Wr_RW;
  logic [DW-1:0]       DataOut;
  logic                Rdy_Dtack;
  logic                busy;

  cpu_bus_master #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_bus_mode(cfg_bus_mode),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .BusMode(BusMode), .Addr(Addr), .Sel(Sel),
    .DataIn(DataIn), .Rd_DS(Rd_DS), .Wr_RW(Wr_RW), .DataOut(DataOut),
    .Rdy_Dtack(Rdy_Dtack), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          id;
    logic [DW-1:0] rdata;
    bit          err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  // Current transaction as seen by the peripheral model.
  bit            cur_mode = 1'b1;
  bit            cur_write;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [DW-1:0] cur_rdata = '0;
  int            cur_ack_delay;
  int            cur_rel_delay;
  bit            cur_early;
  bit            chk_len = 1'b1;
  int            rr_last = NREQ - 1;

  assign DataOut = cur_rdata;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
  endtask

  // Reference model: outcome of one bus cycle from peripheral timing alone.
  function automatic exp_t predict(input int id, input bit wr, input logic [DW-1:0] data,
                                   input int ad, input int rd);
    exp_t e;
    bit   acked;
    int   s_len;
    int   r_len;
    acked   = ad < TIMEOUT;
    s_len   = acked ? ad + 1 : TIMEOUT;
    r_len   = acked ? ((rd < TIMEOUT) ? rd + 1 : TIMEOUT) : 1;
    e.id    = id;
    e.err   = !acked || (acked && rd >= TIMEOUT);
    e.rdata = (!wr && !e.err) ? data : '0;
    e.lat   = 2 + s_len + r_len;
    e.acc   = cyc;
    return e;
  endfunction

  function automatic int next_grant(input logic [NREQ-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- Peripheral model ----------------
  bit ack_on  = 1'b0;
  bit early_p = 1'b0;
  bit prev_act = 1'b0;
  int s_cnt = 0;
  int r_cnt = 0;

  initial Rdy_Dtack = 1'b0;

  always @(negedge clk) begin
    bit act;
    int el;
    act = !Sel && (cur_mode ? (!Rd_DS || !Wr_RW) : !Rd_DS);
    if (rst) begin
      ack_on = 0; early_p = 0; prev_act = 0; s_cnt = 0; r_cnt = 0;
    end else begin
      if (act) begin
        if (s_cnt == 0) begin
          check("strobe_addr", Addr, cur_addr);
          check("strobe_busmode", BusMode, cur_mode);
          if (cur_mode)
            check("strobe_pins", {Rd_DS, Wr_RW}, cur_write ? 2'b10 : 2'b01);
          else
            check("strobe_pins", {Rd_DS, Wr_RW}, {1'b0, !cur_write});
          if (cur_write) check("strobe_datain", DataIn, cur_wdata);
        end
        if (s_cnt == cur_ack_delay) ack_on = 1'b1;
        s_cnt++;
      end else begin
        if (prev_act && chk_len) begin
          el = (cur_ack_delay < TIMEOUT) ? cur_ack_delay + 1 : TIMEOUT;
          check("strobe_len", s_cnt, el);
          check("release_bus", {Sel, Rd_DS, Wr_RW}, 3'b111);
          check("release_addr", Addr, cur_addr);
        end
        s_cnt = 0;
        if (ack_on) begin
          if (r_cnt >= cur_rel_delay) begin
            ack_on = 1'b0;
            r_cnt  = 0;
          end else begin
            r_cnt++;
          end
        end
      end
      // Spurious ack during address setup; must be ignored.
      early_p  = !Sel && !act && !ack_on && cur_early;
      prev_act = act;
    end
    Rdy_Dtack = cur_mode ? (ack_on | early_p) : !(ack_on | early_p);
  end

  // ---------------- Response monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req_ready != '0) check("ready_onehot", $countones(req_ready), 1);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got id=%0d expected no response", resp_id);
        end else begin
          e = exp_q.pop_front();
          check("resp_id", resp_id, e.id);
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", resp_err, e.err);
          check("resp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic wait_grant(output int g);
    int exp_g;
    g = -1;
    exp_g = next_grant(req_valid, rr_last);
    for (int i = 0; i < 60; i++) begin
      #1;
      if (req_ready != '0) begin
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) g = j;
        break;
      end
      @(negedge clk);
    end
    if (g < 0) fail("grant_timeout");
    else check("grant_order", g, exp_g);
  endtask

  task automatic accept(input int g, input bit push);
    cur_write = req_write[g];
    cur_addr  = req_addr[g*AW +: AW];
    cur_wdata = req_wdata[g*DW +: DW];
    rr_last   = g;
    if (push) exp_q.push_back(predict(g, cur_write, cur_rdata, cur_ack_delay, cur_rel_delay));
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !ack_on) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail("resp_timeout");
      exp_q.delete();
    end
  endtask

  task automatic do_txn(input int id, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit mode, input int ad,
                        input int rd, input bit early);
    int g;
    @(negedge clk);
    req_write[id]            = wr;
    req_addr[id*AW +: AW]    = a;
    req_wdata[id*DW +: DW]   = d;
    cfg_bus_mode  = mode;
    cur_mode      = mode;
    cur_ack_delay = ad;
    cur_rel_delay = rd;
    cur_early     = early;
    cur_rdata     = wr ? DW'($urandom) : d;
    req_valid[id] = 1'b1;
    wait_grant(g);
    if (g >= 0) accept(g, 1'b1);
    @(posedge clk);
    #1;
    req_valid    = '0;
    cfg_bus_mode = 1'($urandom_range(0, 1));  // must not affect the running cycle
    wait_done();
  endtask

  task automatic rr_phase(input int n);
    int g;
    @(negedge clk);
    req_write     = 2'b01;
    req_addr      = {AW'($urandom), AW'($urandom)};
    req_wdata     = {DW'($urandom), DW'($urandom)};
    cfg_bus_mode  = 1'b1;
    cur_mode      = 1'b1;
    cur_ack_delay = 0;
    cur_rel_delay = 0;
    cur_early     = 1'b0;
    cur_rdata     = DW'($urandom);
    req_valid     = '1;
    for (int k = 0; k < n; k++) begin
      wait_grant(g);
      if (g < 0) break;
      accept(g, 1'b1);
      if (k == n - 1) begin
        @(posedge clk);
        #1;
        req_valid = '0;
      end
      wait_done();
    end
    req_valid = '0;
  endtask

  function automatic int pick_ack();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return int'($urandom_range(2, 6));
      3: return TIMEOUT - 1;
      4: return TIMEOUT + 3;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  function automatic int pick_rel();
    case ($urandom_range(0, 5))
      0: return TIMEOUT - 1;
      1: return TIMEOUT;
      2: return TIMEOUT + 4;
      default: return int'($urandom_range(0, 2));
    endcase
  endfunction

  initial begin
    int g;
    rst          = 1'b1;
    cfg_bus_mode = 1'b1;
    req_valid    = '0;
    req_write    = '0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_strobes", {BusMode, Sel, Rd_DS, Wr_RW}, 4'hF);
    check("reset_addr", Addr, 0);
    check("reset_datain", DataIn, 0);
    check("reset_ready", req_ready, 0);
    check("reset_resp", {resp_valid, resp_err, resp_id}, 0);
    check("reset_rdata", resp_rdata, 0);
    check("reset_busy", busy, 0);

    // Directed cases
    do_txn(0, 1'b1, 24'h000003, 16'h5A12, 1'b1, 1, 0, 1'b0);            // Intel write
    do_txn(1, 1'b0, 24'h000007, 16'h1ABC, 1'b0, 0, 0, 1'b0);            // Motorola read
    do_txn(0, 1'b0, 24'h000010, 16'hBEEF, 1'b1, TIMEOUT + 3, 0, 1'b0);  // strobe timeout
    do_txn(1, 1'b0, 24'h000020, 16'h1234, 1'b1, 0, TIMEOUT + 2, 1'b0);  // stuck release
    do_txn(0, 1'b0, 24'h000030, 16'h4321, 1'b1, TIMEOUT - 1, TIMEOUT - 1, 1'b0);
    do_txn(1, 1'b0, 24'h000040, 16'h7777, 1'b0, TIMEOUT + 3, 0, 1'b1);  // early ack ignored
    do_txn(0, 1'b1, 24'h000050, 16'h0F0F, 1'b0, 2, 1, 1'b1);
    rr_phase(4);

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      do_txn(int'($urandom_range(0, NREQ - 1)), 1'($urandom_range(0, 1)), AW'($urandom),
             DW'($urandom), 1'($urandom_range(0, 1)), pick_ack(), pick_rel(),
             ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a strobe
    @(negedge clk);
    req_write[0]      = 1'b0;
    req_addr[0 +: AW] = 24'h000055;
    cfg_bus_mode      = 1'b1;
    cur_mode          = 1'b1;
    cur_ack_delay     = TIMEOUT + 3;
    cur_rel_delay     = 0;
    cur_early         = 1'b0;
    chk_len           = 1'b0;
    req_valid[0]      = 1'b1;
    wait_grant(g);
    if (g >= 0) accept(g, 1'b0);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    check("mid_strobe_rd", Rd_DS, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_bus", {Sel, Rd_DS, Wr_RW}, 3'b111);
    check("abort_busy", busy, 1'b0);
    check("abort_resp", resp_valid, 1'b0);
    rr_last = NREQ - 1;
    repeat (25) @(negedge clk);
    chk_len = 1'b1;
    rr_phase(2);

    if (exp_q.size() != 0) fail("pending_responses");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Bus master that drives the CPU configuration interface (BusMode, Addr, Sel, DataIn, Rd_DS, Wr_RW, DataOut, Rdy_Dtack) on behalf of NREQ internal requesters.
- Round-robin arbitration grants one requester at a time. The block then runs one complete bus cycle in Intel mode (BusMode=1) or Motorola mode (BusMode=0) and returns read data or a timeout error.
- It sits between the configuration sequencers (lookup-table loader, status poller) and the cell-config peripheral.

Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 24, bus address width
- DW, 16, data width, equal to packed CellCfgType {FWD, VPI}
- TIMEOUT, 16, maximum cycles to wait for ack assert or release (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_bus_mode  in  1  1=Intel, 0=Motorola; sampled at grant
- req_valid  in  NREQ  request pending, held until accepted
- req_ready  out  NREQ  one-hot one-cycle accept pulse
- req_write  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*AW  packed addresses; requester i uses slice [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- resp_valid  out  1  one-cycle completion pulse
- resp_id  out  $clog2(NREQ)  requester being answered
- resp_rdata  out  DW  read data; 0 on write or error
- resp_err  out  1  timeout occurred
- BusMode  out  1  registered copy of the sampled mode
- Addr  out  AW  bus address
- Sel  out  1  chip select, active low
- DataIn  out  DW  write data to the peripheral
- Rd_DS  out  1  Intel: read strobe, active low. Motorola: data strobe, active low
- Wr_RW  out  1  Intel: write strobe, active low. Motorola: 1=read, 0=write
- DataOut  in  DW  read data from the peripheral
- Rdy_Dtack  in  1  Intel: Rdy, active high. Motorola: Dtack, active low
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, Sel=1, Rd_DS=1, Wr_RW=1, BusMode=1, Addr=0, DataIn=0, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, resp_id=0, RR pointer=NREQ-1, busy=0.
- Reset mid-cycle aborts the bus cycle. All strobes are deasserted on the next edge and no response is issued.
- Ack definition: ack = (BusMode ? Rdy_Dtack : ~Rdy_Dtack).
- IDLE state:
  - If any req_valid is high, grant the first set bit searching from ptr+1 and wrapping modulo NREQ.
  - Pulse req_ready[g], latch write/addr/wdata/id, latch cfg_bus_mode, set ptr=g, go to SETUP.
  - Exactly one grant per cycle.
- SETUP state (1 cycle):
  - Drive Addr and Sel=0, and drive DataIn on writes.
  - Motorola: Wr_RW = ~write. Both strobes remain high.
  - Go to STROBE.
- STROBE state:
  - Intel: assert Rd_DS=0 (read) or Wr_RW=0 (write).
  - Motorola: assert Rd_DS=0 and keep Wr_RW as set in SETUP.
  - A cycle counter starts at 0.
  - On the first cycle with ack=1: capture DataOut into resp_rdata if the access is a read, then go to RELEASE.
  - If the counter reaches TIMEOUT-1 without ack: set err, set rdata=0, go to RELEASE.
  - Ack is checked from the first STROBE cycle, so minimum strobe width is 1 cycle.
- RELEASE state:
  - Deassert strobes. Sel=1, Wr_RW=1. Addr and DataIn hold their values.
  - Wait for ack=0, limited to TIMEOUT cycles. If the limit is hit, set err.
  - Go to RESP.
- RESP state (1 cycle):
  - resp_valid=1 with resp_id, resp_rdata, and resp_err.
  - Go to IDLE. The next grant can occur on the IDLE cycle that follows.
- Minimum latency: accept to resp_valid is 4 cycles (SETUP, STROBE, RELEASE, RESP) with immediate ack assertion and release.
- Requests arriving while busy: held by the requester and not accepted.
- cfg_bus_mode changes while busy: ignored until the next grant.
- Pre-strobe ack: ack seen in SETUP is ignored. Only ack in STROBE completes a cycle.

Test Plan:
- Intel write: req0 write addr=0x000003 data=0x5A12, Rdy high on 2nd STROBE cycle -> Wr_RW low for 2 cycles, Rd_DS stays high, resp_valid 5 cycles after accept, id=0, err=0.
- Motorola read: mode=0, req1 read addr=0x000007, Dtack low on 1st STROBE cycle with DataOut=0x1ABC -> Wr_RW=1 and Rd_DS=0 for 1 cycle; resp_rdata=0x1ABC, id=1.
- Round-robin: NREQ=2, both requesters hold valid for 4 transactions -> grant order 0,1,0,1, and each req_ready is one-hot.
- Timeout: Intel read with Rdy never asserted, TIMEOUT=16 -> strobe low for 16 cycles, then resp_err=1 and rdata=0; bus returns to Sel=1.
- Stuck ack release: Rdy held high after the strobe ends -> RELEASE lasts 16 cycles, then resp_err=1.
- Reset in STROBE: assert rst for 1 cycle -> next edge Sel=1, Rd_DS=1, Wr_RW=1, busy=0, and no resp_valid.
